// File: rtl/max_pooling_fprop1_pkg.sv
// Shared definitions for the max_pooling_fprop1 signed divider.
//
// Contents:
//   DIV_W    default operand/result width of the divider (17)
//   CNT_W    width of the quotient-bit counter (enough for DIV_W-1)
//   state_t  divider control states IDLE -> CALC -> FIXUP -> DONE

package max_pooling_fprop1_pkg;

    localparam int DIV_W = 17;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

endpackage

// File: rtl/max_pooling_fprop1_sdiv_step.sv
// One radix-2 restoring division step (purely combinational).
//
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor magnitude when it fits, producing one quotient bit.
//
// Ports:
//   r_in   in   W     partial remainder from the previous step (unsigned)
//   a_bit  in   1     next dividend magnitude bit, MSB first
//   d      in   W+1   divisor magnitude (unsigned, zero-extended)
//   r_out  out  W     updated partial remainder
//   q_bit  out  1     quotient bit produced by this step

module max_pooling_fprop1_sdiv_step #(
    parameter int W = 17
) (
    input  logic [W-1:0] r_in,
    input  logic         a_bit,
    input  logic [W:0]   d,
    output logic [W-1:0] r_out,
    output logic         q_bit
);

    logic [W:0] shifted;

    // The shifted remainder never exceeds the dividend magnitude, so the
    // restored/subtracted value always fits back into W bits.
    always_comb begin
        shifted = {r_in, a_bit};
        q_bit   = (shifted >= d);
        r_out   = W'(q_bit ? (shifted - d) : shifted);
    end

endmodule

// File: rtl/max_pooling_fprop1_sdiv_17s_17s_17_seq.sv
// Multi-cycle signed divider (truncating quotient, remainder follows the
// dividend sign) with an ap_start/ap_ready/ap_done/ap_idle handshake.
// Restoring division on operand magnitudes, one quotient bit per cycle,
// then a sign fix-up cycle and a one-cycle done pulse.
//
// Ports:
//   ap_clk       in   1      clock, rising edge
//   ap_rst_n     in   1      asynchronous active-low reset
//   ap_start     in   1      request, operands sampled in IDLE
//   ap_ready     out  1      operands latched this cycle
//   ap_done      out  1      quot/rem valid this cycle
//   ap_idle      out  1      divider idle
//   din0         in   W      dividend (signed)
//   din1         in   W      divisor (signed)
//   div_by_zero  out  1      only with MAX_POOLING_FPROP1_SDIV_DBZ_EN: last
//                            result came from a zero divisor
//   quot         out  W      quotient, held until the next ap_done
//   rem          out  W      remainder, held until the next ap_done
//
// Build option: MAX_POOLING_FPROP1_SDIV_DBZ_EN adds the div_by_zero flag and
// saturates the quotient on a zero divisor instead of returning -1.

module max_pooling_fprop1_sdiv_17s_17s_17_seq
    import max_pooling_fprop1_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIV_W,
    parameter int din1_WIDTH = DIV_W,
    parameter int dout_WIDTH = DIV_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
`ifdef MAX_POOLING_FPROP1_SDIV_DBZ_EN
    output logic                  div_by_zero,
`endif
    output logic [dout_WIDTH-1:0] quot,
    output logic [dout_WIDTH-1:0] rem
);

    localparam int W = din0_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_mag;
    logic [W:0]       d_mag;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     q_acc;
    logic             sign0;
    logic             sign1;
    logic             div_zero;

    logic [W-1:0]     din0_abs;
    logic [W-1:0]     din1_abs;
    logic [W-1:0]     r_step;
    logic             q_step;
    logic [W-1:0]     q_signed;
    logic [W-1:0]     r_signed;
    logic [W-1:0]     quot_fix;

    // Negating in W bits gives the exact unsigned magnitude even for the most
    // negative operand (-65536 -> 0x10000), so no extra bit is needed to hold
    // the dividend; the divisor is zero-extended for the W+1 bit comparison.
    always_comb begin
        din0_abs = din0[W-1] ? (-din0) : din0;
        din1_abs = din1[W-1] ? (-din1) : din1;
    end

    max_pooling_fprop1_sdiv_step #(
        .W (W)
    ) u_step (
        .r_in  (r_acc),
        .a_bit (a_mag[W-1]),
        .d     (d_mag),
        .r_out (r_step),
        .q_bit (q_step)
    );

    // A zero divisor makes every step "fit", which leaves the dividend
    // magnitude in the remainder; negating it restores din0 as the remainder.
    always_comb begin
        q_signed = (sign0 ^ sign1) ? (-q_acc) : q_acc;
        r_signed = sign0 ? (-r_acc) : r_acc;
`ifdef MAX_POOLING_FPROP1_SDIV_DBZ_EN
        if (div_zero) begin
            quot_fix = sign0 ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            quot_fix = q_signed;
        end
`else
        quot_fix = div_zero ? {W{1'b1}} : q_signed;
`endif
    end

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ap_start only matters in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ap_start) state_next = CALC;
            CALC:    if (cnt == LAST_CNT) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        ap_idle  = (state == IDLE);
        ap_ready = (state == IDLE) && ap_start;
        ap_done  = (state == DONE);
    end

    // Datapath: latch operands on acceptance, iterate in CALC, publish the
    // signed result in FIXUP so it is visible during the DONE pulse.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt         <= '0;
            a_mag       <= '0;
            d_mag       <= '0;
            r_acc       <= '0;
            q_acc       <= '0;
            sign0       <= 1'b0;
            sign1       <= 1'b0;
            div_zero    <= 1'b0;
            quot        <= '0;
            rem         <= '0;
`ifdef MAX_POOLING_FPROP1_SDIV_DBZ_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        cnt      <= '0;
                        a_mag    <= din0_abs;
                        d_mag    <= {1'b0, din1_abs};
                        r_acc    <= '0;
                        q_acc    <= '0;
                        sign0    <= din0[W-1];
                        sign1    <= din1[W-1];
                        div_zero <= (din1 == '0);
                    end
                end
                CALC: begin
                    a_mag <= {a_mag[W-2:0], 1'b0};
                    r_acc <= r_step;
                    q_acc <= {q_acc[W-2:0], q_step};
                    cnt   <= cnt + CNT_W'(1);
                end
                FIXUP: begin
                    quot        <= quot_fix;
                    rem         <= r_signed;
`ifdef MAX_POOLING_FPROP1_SDIV_DBZ_EN
                    div_by_zero <= div_zero;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_pooling_fprop1_sdiv_17s_17s_17_seq.sv
// Self-checking bench for max_pooling_fprop1_sdiv_17s_17s_17_seq.
// Directed operand pairs with hand-computed results are issued by
// apply_stimulus, which queues the expected response; an independent monitor
// compares each ap_done against the queue, checks the 19-cycle latency and
// that quot/rem hold steady between done pulses.
// Honours MAX_POOLING_FPROP1_SDIV_DBZ_EN for the zero-divisor expectations.

module tb_max_pooling_fprop1_sdiv_17s_17s_17_seq;

    typedef struct {
        logic [16:0] q;
        logic [16:0] r;
        logic        dbz;
        int          ready_cycle;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_idle;
    logic [16:0] din0 = '0;
    logic [16:0] din1 = '0;
    logic [16:0] quot;
    logic [16:0] rem;
`ifdef MAX_POOLING_FPROP1_SDIV_DBZ_EN
    logic        div_by_zero;
`endif

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          last_ready = 0;
    logic        prev_held = 1'b0;
    logic [16:0] held_q = '0;
    logic [16:0] held_r = '0;

    max_pooling_fprop1_sdiv_17s_17s_17_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .din0        (din0),
        .din1        (din1),
`ifdef MAX_POOLING_FPROP1_SDIV_DBZ_EN
        .div_by_zero (div_by_zero),
`endif
        .quot        (quot),
        .rem         (rem)
    );

    // 10 ns clock and a free-running cycle count used for latency checks.
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cycle <= cycle + 1;

    // Single comparison point: every check goes through here.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d",
                     name, actual, required, cycle);
        end
    endtask

    // Present one operand pair, wait (bounded) for ap_ready and queue the
    // expected result. keep leaves ap_start high for back-to-back requests.
    task automatic apply_stimulus(input logic [16:0] a, input logic [16:0] b,
                                  input logic [16:0] exp_q,
                                  input logic [16:0] exp_r,
                                  input logic exp_dbz, input logic keep);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge ap_clk);
        din0     = a;
        din1     = b;
        ap_start = 1'b1;
        #1;
        while (!ap_ready && waited < 60) begin
            @(negedge ap_clk);
            #1;
            waited++;
        end
        if (!ap_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout actual=0 required=1 a=0x%05h b=0x%05h", a, b);
            ap_start = 1'b0;
            prev_held = 1'b0;
            return;
        end
        if (prev_held) check_output("ready_interval", cycle - last_ready, 20);
        last_ready    = cycle;
        prev_held     = keep;
        e.q           = exp_q;
        e.r           = exp_r;
        e.dbz         = exp_dbz;
        e.ready_cycle = cycle;
        sb.push_back(e);
        @(posedge ap_clk);
        #1;
        if (!keep) ap_start = 1'b0;
    endtask

    // Monitor: compares results on ap_done, otherwise checks the outputs hold.
    always @(negedge ap_clk) begin
        exp_t e;
        if (!ap_rst_n) begin
            sb.delete();
            held_q = '0;
            held_r = '0;
        end else if (ap_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 required=0 at cycle %0d", cycle);
            end else begin
                e = sb.pop_front();
                check_output("quot", quot, e.q);
                check_output("rem", rem, e.r);
                check_output("latency", cycle - e.ready_cycle, 19);
`ifdef MAX_POOLING_FPROP1_SDIV_DBZ_EN
                check_output("div_by_zero", div_by_zero, e.dbz);
`endif
            end
            held_q = quot;
            held_r = rem;
        end else begin
            check_output("hold_quot", quot, held_q);
            check_output("hold_rem", rem, held_r);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        $display("[TB] start");

        // Reset state.
        repeat (3) @(negedge ap_clk);
        check_output("rst_idle", ap_idle, 1);
        check_output("rst_ready", ap_ready, 0);
        check_output("rst_done", ap_done, 0);
        check_output("rst_quot", quot, 0);
        check_output("rst_rem", rem, 0);
        ap_rst_n = 1'b1;

        // Sign combinations.
        apply_stimulus(17'd100, 17'd7, 17'h0000E, 17'h00002, 1'b0, 1'b0);
        apply_stimulus(-17'sd100, 17'd7, 17'h1FFF2, 17'h1FFFE, 1'b0, 1'b0);
        apply_stimulus(17'd100, -17'sd7, 17'h1FFF2, 17'h00002, 1'b0, 1'b0);
        apply_stimulus(-17'sd100, -17'sd7, 17'h0000E, 17'h1FFFE, 1'b0, 1'b0);

        // Range boundaries and overflow wrap.
        apply_stimulus(17'h10000, 17'h1FFFF, 17'h10000, 17'h00000, 1'b0, 1'b0);
        apply_stimulus(17'h10000, 17'h00001, 17'h10000, 17'h00000, 1'b0, 1'b0);
        apply_stimulus(17'h0FFFF, 17'h0FFFF, 17'h00001, 17'h00000, 1'b0, 1'b0);
        apply_stimulus(17'h0FFFF, 17'h00001, 17'h0FFFF, 17'h00000, 1'b0, 1'b0);
        apply_stimulus(17'h0FFFF, 17'h10000, 17'h00000, 17'h0FFFF, 1'b0, 1'b0);
        apply_stimulus(17'd7, 17'd100, 17'h00000, 17'h00007, 1'b0, 1'b0);
        apply_stimulus(-17'sd7, 17'd100, 17'h00000, 17'h1FFF9, 1'b0, 1'b0);
        apply_stimulus(17'd0, 17'd5, 17'h00000, 17'h00000, 1'b0, 1'b0);

        // Zero divisor.
`ifdef MAX_POOLING_FPROP1_SDIV_DBZ_EN
        apply_stimulus(17'd1234, 17'd0, 17'h0FFFF, 17'h004D2, 1'b1, 1'b0);
        apply_stimulus(-17'sd5, 17'd0, 17'h10000, 17'h1FFFB, 1'b1, 1'b0);
`else
        apply_stimulus(17'd1234, 17'd0, 17'h1FFFF, 17'h004D2, 1'b1, 1'b0);
        apply_stimulus(-17'sd5, 17'd0, 17'h1FFFF, 17'h1FFFB, 1'b1, 1'b0);
`endif
        apply_stimulus(17'd9, 17'd3, 17'h00003, 17'h00000, 1'b0, 1'b0);

        // ap_start held high across three back-to-back operations.
        apply_stimulus(17'd1000, 17'd3, 17'h0014D, 17'h00001, 1'b0, 1'b1);
        apply_stimulus(-17'sd1000, 17'd3, 17'h1FEB3, 17'h1FFFF, 1'b0, 1'b1);
        apply_stimulus(17'd32767, -17'sd128, 17'h1FF01, 17'h0007F, 1'b0, 1'b0);

        // Abort mid-calculation with reset; the queued result must never appear.
        apply_stimulus(17'd500, 17'd9, 17'h00037, 17'h00005, 1'b0, 1'b0);
        repeat (7) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        check_output("abort_idle", ap_idle, 1);
        check_output("abort_done", ap_done, 0);
        check_output("abort_quot", quot, 0);
        check_output("abort_rem", rem, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (25) @(negedge ap_clk);

        // Fresh operation after the abort.
        apply_stimulus(17'd100, 17'd7, 17'h0000E, 17'h00002, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge ap_clk);
            waited++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0 pending results", sb.size());
        end
        repeat (3) @(negedge ap_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
